// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Used by the transmit arbiter and its rotating picker.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Rotating-priority requester pick.
// Finds the first asserted request at or after ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any_vld
);

  logic [PW-1:0] j;

  // Scan upward from ptr and keep the first hit.
  always_comb begin
    idx     = '0;
    any_vld = 1'b0;
    j       = '0;
    for (int i = 0; i < N; i++) begin
      j = PW'((int'(ptr) + i) % N);
      if (!any_vld && req[j]) begin
        any_vld = 1'b1;
        idx     = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter feeding one UART transmitter.
// A granted requester owns the link until last byte or gap timeout.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       gap_abort
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(GAP_TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [CW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              gap_abort_q, gap_abort_d;

  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              own_valid;
  logic              own_last;
  logic [BYTE_W-1:0] own_data;
  logic              can_load;
  logic              own_hs;
  logic [PW-1:0]     next_ptr;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .idx     (pick_idx),
    .any_vld (pick_any)
  );

  // Select the current owner's byte lane and flags.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == PW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*8 +: 8];
      end
    end
  end

  assign can_load = (state_q == LOCK) && (!tx_valid_q || tx_ready);
  assign own_hs   = can_load && own_valid;
  assign next_ptr = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Only the owner sees ready, and only when the output slot frees.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == PW'(i)) req_ready[i] = can_load;
    end
  end

  // Next-state: arbitration, packet ownership, output slot, gap timer.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    gap_cnt_d   = gap_cnt_q;
    gap_abort_d = 1'b0;
    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gap_cnt_d = '0;
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (own_hs) begin
          tx_data_d  = own_data;
          tx_valid_d = 1'b1;
        end
        if (own_valid) gap_cnt_d = '0;
        else           gap_cnt_d = gap_cnt_q + 1'b1;
        if (own_hs && own_last) begin
          state_d   = IDLE;
          rr_ptr_d  = next_ptr;
          gap_cnt_d = '0;
        end else if (!own_valid &&
                     gap_cnt_q == CW'(GAP_TIMEOUT - 1)) begin
          state_d     = IDLE;
          rr_ptr_d    = next_ptr;
          gap_cnt_d   = '0;
          gap_abort_d = 1'b1;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      gap_cnt_q   <= '0;
      gap_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_abort_q <= gap_abort_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == LOCK);
  assign gap_abort = gap_abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random packets
// checked against a queue-level round-robin reference model.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int GT = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic [1:0]     grant_id;
  logic           busy;
  logic           gap_abort;

  uart_tx_arb #(
    .NUM_REQ     (N),
    .GAP_TIMEOUT (GT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .gap_abort (gap_abort)
  );

  always #5 clk = ~clk;

  logic [8:0] srcq[N][$];
  logic [7:0] outq[$];
  int         gq[$];
  bit         tx_rdy_drv = 1'b1;
  bit         rand_rdy = 1'b0;
  bit         busy_prev = 1'b0;
  int         proto_bad = 0;
  int         errs = 0;
  int         chks = 0;

  function automatic bit same_b(logic [7:0] a[$], logic [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[k]) if (a[k] !== b[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit same_i(int a[$], int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[k]) if (a[k] != b[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive sources from their queues at the falling edge,
  // note handshakes, then advance to the next falling edge.
  task automatic tick();
    logic [N-1:0] hs;
    logic         hst;
    logic [7:0]   d;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[i*8 +: 8] = srcq[i][0][7:0];
        req_last[i]       = srcq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
    tx_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : tx_rdy_drv;
    #1;
    hs  = req_valid & req_ready;
    hst = tx_valid & tx_ready;
    d   = tx_data;
    for (int i = 0; i < N; i++)
      if (req_ready[i] && !(busy && int'(grant_id) == i)) proto_bad++;
    @(negedge clk);
    for (int i = 0; i < N; i++) if (hs[i]) void'(srcq[i].pop_front());
    if (hst) outq.push_back(d);
    if (busy && !busy_prev) gq.push_back(int'(grant_id));
    busy_prev = busy;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) srcq[i].delete();
    rst_n      = 1'b0;
    tx_rdy_drv = 1'b1;
    rand_rdy   = 1'b0;
    tick();
    rst_n = 1'b1;
    outq.delete();
    gq.delete();
    busy_prev = 1'b0;
    proto_bad = 0;
  endtask

  task automatic run_idle(input int max, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (pending() || tx_valid === 1'b1 || busy === 1'b1) begin
      if (n == max) begin
        to = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    chks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_tx: valid=%b data=%h want 0/00", tx_valid, tx_data);
    end
    chks++;
    if (busy !== 1'b0 || gap_abort !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: busy=%b gap=%b want 0/0", busy, gap_abort);
    end
    chks++;
    if (grant_id !== 2'd0 || req_ready !== 4'b0000) begin
      errs++;
      $display("FAIL reset_grant: gid=%0d rdy=%b want 0/0000", grant_id, req_ready);
    end
  endtask

  task automatic test_single();
    bit to;
    logic [7:0] exp[$];
    do_reset();
    srcq[1].push_back({1'b0, 8'hA5});
    srcq[1].push_back({1'b1, 8'h3C});
    tick();
    chks++;
    if (busy !== 1'b1 || grant_id !== 2'd1 || tx_valid !== 1'b0 ||
        req_ready !== 4'b0010) begin
      errs++;
      $display("FAIL single_grant: busy=%b gid=%0d txv=%b rdy=%b want 1/1/0/0010",
               busy, grant_id, tx_valid, req_ready);
    end
    tick();
    chks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      errs++;
      $display("FAIL single_latency: txv=%b data=%h want 1/a5", tx_valid, tx_data);
    end
    tick();
    chks++;
    if (busy !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
      errs++;
      $display("FAIL single_release: busy=%b txv=%b data=%h want 0/1/3c",
               busy, tx_valid, tx_data);
    end
    run_idle(20, to);
    exp = '{8'hA5, 8'h3C};
    chks++;
    if (to || !same_b(outq, exp)) begin
      errs++;
      $display("FAIL single_order: to=%b got=%p want=%p", to, outq, exp);
    end
    srcq[0].push_back({1'b1, 8'h01});
    srcq[2].push_back({1'b1, 8'h02});
    tick();
    chks++;
    if (busy !== 1'b1 || grant_id !== 2'd2) begin
      errs++;
      $display("FAIL single_rrptr: busy=%b gid=%0d want 1/2", busy, grant_id);
    end
    run_idle(40, to);
  endtask

  task automatic test_contention();
    bit to;
    logic [7:0] exp[$];
    int eg[$];
    do_reset();
    srcq[0] = '{{1'b0, 8'h01}, {1'b1, 8'h02}};
    srcq[2] = '{{1'b0, 8'h21}, {1'b1, 8'h22}};
    srcq[3] = '{{1'b0, 8'h31}, {1'b1, 8'h32}};
    run_idle(60, to);
    exp = '{8'h01, 8'h02, 8'h21, 8'h22, 8'h31, 8'h32};
    eg  = '{0, 2, 3};
    chks++;
    if (to || !same_i(gq, eg)) begin
      errs++;
      $display("FAIL contention_grants: to=%b got=%p want=%p", to, gq, eg);
    end
    chks++;
    if (!same_b(outq, exp)) begin
      errs++;
      $display("FAIL contention_bytes: got=%p want=%p", outq, exp);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad;
    logic [7:0] b[3];
    logic [7:0] exp[$];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      b[k] = 8'($urandom);
      srcq[2].push_back({k == 2, b[k]});
    end
    tick();
    tick();
    tx_rdy_drv = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (tx_valid !== 1'b1 || tx_data !== b[0] ||
          req_ready !== 4'b0000 || busy !== 1'b1) bad++;
    end
    chks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL backpressure_stall: bad_cycles=%0d want 0 (last data=%h want %h)",
               bad, tx_data, b[0]);
    end
    tx_rdy_drv = 1'b1;
    run_idle(40, to);
    exp = '{b[0], b[1], b[2]};
    chks++;
    if (to || !same_b(outq, exp)) begin
      errs++;
      $display("FAIL backpressure_order: to=%b got=%p want=%p", to, outq, exp);
    end
  endtask

  task automatic test_timeout();
    bit to;
    logic [7:0] exp[$];
    do_reset();
    srcq[0].push_back({1'b0, 8'h11});
    srcq[1].push_back({1'b1, 8'h22});
    tick();
    chks++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      errs++;
      $display("FAIL timeout_grant0: busy=%b gid=%0d want 1/0", busy, grant_id);
    end
    tick();
    for (int c = 3; c <= 11; c++) begin
      tick();
      chks++;
      if (gap_abort !== (c == 10)) begin
        errs++;
        $display("FAIL timeout_pulse_c%0d: gap=%b want %b", c, gap_abort, c == 10);
      end
      if (c == 10) begin
        chks++;
        if (busy !== 1'b0) begin
          errs++;
          $display("FAIL timeout_busy: busy=%b want 0", busy);
        end
      end
      if (c == 11) begin
        chks++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
          errs++;
          $display("FAIL timeout_next: busy=%b gid=%0d want 1/1", busy, grant_id);
        end
      end
    end
    run_idle(40, to);
    exp = '{8'h11, 8'h22};
    chks++;
    if (to || !same_b(outq, exp)) begin
      errs++;
      $display("FAIL timeout_bytes: to=%b got=%p want=%p", to, outq, exp);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [7:0] exp[$];
    do_reset();
    srcq[0].push_back({1'b1, 8'h0F});
    run_idle(20, to);
    srcq[3] = '{{1'b0, 8'h71}, {1'b1, 8'h72}};
    tick();
    tick();
    tx_rdy_drv = 1'b0;
    tick();
    tick();
    chks++;
    if (busy !== 1'b1 || grant_id !== 2'd3 || tx_valid !== 1'b1) begin
      errs++;
      $display("FAIL resetmid_setup: busy=%b gid=%0d txv=%b want 1/3/1",
               busy, grant_id, tx_valid);
    end
    do_reset();
    chks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
        gap_abort !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0000) begin
      errs++;
      $display("FAIL resetmid_outputs: txv=%b d=%h busy=%b gap=%b gid=%0d rdy=%b",
               tx_valid, tx_data, busy, gap_abort, grant_id, req_ready);
    end
    srcq[0].push_back({1'b1, 8'h55});
    srcq[3].push_back({1'b1, 8'h66});
    tick();
    chks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL resetmid_rrptr: gid=%0d busy=%b want 0/1", grant_id, busy);
    end
    run_idle(40, to);
    exp = '{8'h55, 8'h66};
    chks++;
    if (to || !same_b(outq, exp)) begin
      errs++;
      $display("FAIL resetmid_noreplay: to=%b got=%p want=%p", to, outq, exp);
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [7:0] exp[$];
    int eg[$];
    do_reset();
    srcq[3] = '{{1'b1, 8'hB1}, {1'b1, 8'hC1}};
    tick();
    srcq[0].push_back({1'b1, 8'hD1});
    run_idle(40, to);
    eg  = '{3, 0, 3};
    exp = '{8'hB1, 8'hD1, 8'hC1};
    chks++;
    if (to || !same_i(gq, eg)) begin
      errs++;
      $display("FAIL wrap_grants: to=%b got=%p want=%p", to, gq, eg);
    end
    chks++;
    if (!same_b(outq, exp)) begin
      errs++;
      $display("FAIL wrap_bytes: got=%p want=%p", outq, exp);
    end
  endtask

  // Reference: every requester keeps its queue valid, so each
  // arbitration takes the first non-empty queue from the pointer.
  task automatic test_random();
    bit to;
    logic [8:0] mq[N][$];
    logic [7:0] exp[$];
    int eg[$];
    int ptr;
    int p;
    logic [8:0] e;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int k = 0; k < np; k++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int m = 0; m < len; m++)
            srcq[i].push_back({m == len - 1, 8'($urandom)});
        end
        mq[i] = srcq[i];
      end
      exp.delete();
      eg.delete();
      ptr = 0;
      forever begin
        p = -1;
        for (int s = 0; s < N; s++)
          if (p < 0 && mq[(ptr + s) % N].size() > 0) p = (ptr + s) % N;
        if (p < 0) break;
        eg.push_back(p);
        do begin
          e = mq[p].pop_front();
          exp.push_back(e[7:0]);
        end while (!e[8]);
        ptr = (p + 1) % N;
      end
      rand_rdy = 1'b1;
      run_idle(2000, to);
      rand_rdy = 1'b0;
      chks++;
      if (to || !same_i(gq, eg)) begin
        errs++;
        $display("FAIL random%0d_grants: to=%b got=%p want=%p", it, to, gq, eg);
      end
      chks++;
      if (!same_b(outq, exp)) begin
        errs++;
        $display("FAIL random%0d_bytes: got_n=%0d want_n=%0d",
                 it, outq.size(), exp.size());
      end
      chks++;
      if (proto_bad != 0) begin
        errs++;
        $display("FAIL random%0d_ready_owner: stray_ready=%0d want 0", it, proto_bad);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit hit, errors=%0d checks=%0d", errs, chks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter GAP_TIMEOUT, default 1024, idle cycles tolerated mid-packet before the grant is revoked (>=2).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port req_data, input, NUM_REQ*8, byte per requester; requester i occupies bits [8i+7:8i].
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester byte valid.
REQ-007 SHALL have port req_last, input, NUM_REQ, per-requester end-of-packet flag, qualified by req_valid.
REQ-008 SHALL have port req_ready, output, NUM_REQ, per-requester byte accept.
REQ-009 SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-010 SHALL have port tx_valid, output, 1, byte offer to the UART transmitter.
REQ-011 SHALL have port tx_ready, input, 1, UART transmitter able to accept.
REQ-012 SHALL have port grant_id, output, $clog2(NUM_REQ), index of current owner; valid only while busy.
REQ-013 SHALL have port busy, output, 1, high while a requester holds the grant.
REQ-014 SHALL have port gap_abort, output, 1, one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 SHALL transfer a byte on any interface only on a rising edge with valid and ready both high.
REQ-016 SHALL implement FSM with states IDLE (no owner) and LOCK (owner granted).
REQ-017 SHALL, in IDLE with any req_valid high, select the first requester at or after rr_ptr (wrapping modulo NUM_REQ), register it into grant_id, and enter LOCK next cycle.
REQ-018 SHALL keep every req_ready low in IDLE; one idle cycle per arbitration is required.
REQ-019 SHALL drive req_ready[grant_id] = LOCK && (!tx_valid || tx_ready), and all other req_ready bits low.
REQ-020 SHALL hold the output register as one entry: on owner handshake load tx_data and set tx_valid; otherwise clear tx_valid when tx_ready is high.
REQ-021 SHALL keep tx_data and tx_valid stable while tx_valid is high and tx_ready is low.
REQ-022 SHALL, on accepting a byte with req_last high, return to IDLE next cycle and set rr_ptr = (grant_id+1) mod NUM_REQ; the final byte still drains from the output register.
REQ-023 SHALL count consecutive LOCK cycles with req_valid[grant_id] low, and clear the count whenever that bit is high.
REQ-024 SHALL, when the count reaches GAP_TIMEOUT, return to IDLE, pulse gap_abort for one cycle, and advance rr_ptr as in REQ-022.
REQ-025 SHALL ignore requests from non-owners during LOCK; a packet is never interleaved with another.
REQ-026 SHALL allow a requester releasing by req_last to regain the grant only after all other valid requesters have been served (round-robin fairness).
REQ-027 SHALL give latency of 2 cycles from req_valid rising in IDLE (cycle 0) to tx_valid high (cycle 2) when tx_ready is high.
REQ-028 SHALL allow tx_valid to fall and the next owner to start in back-to-back packets with no extra bubble beyond REQ-018.

Reset
REQ-029 SHALL, with rst_n low at an edge, set state=IDLE, rr_ptr=0, grant_id=0, busy=0, gap_abort=0, tx_valid=0, tx_data=8'h00, req_ready=0, and gap count=0.
REQ-030 SHALL discard any in-flight byte and partial packet on reset mid-operation; no byte is replayed.

Structure
REQ-031 SHALL place the FSM state encodings (IDLE=1'b0, LOCK=1'b1) in shared package uart_pkg alongside the other UART constants.
REQ-032 SHALL implement the rotating priority pick as sub-module rr_pick: combinational, inputs req vector and rr_ptr, outputs index and any-valid.

Verification
REQ-033 SHALL cover a single packet: req 1 sends 8'hA5, 8'h3C(last), tx_ready always high -> tx_valid at cycle 2, bytes A5 then 3C in order, busy falls after 3C is accepted, rr_ptr=2.
REQ-034 SHALL cover contention: reqs 0, 2 and 3 all valid with 2-byte packets from reset -> grant order 0, 2, 3, with no byte interleaving.
REQ-035 SHALL cover backpressure: tx_ready held low 20 cycles with tx_valid high -> tx_data is stable and req_ready[owner] stays low throughout.
REQ-036 SHALL cover timeout: GAP_TIMEOUT=8, owner 0 sends 1 non-last byte then drops valid -> gap_abort pulses exactly 8 cycles later, busy=0, and req 1 is granted next.
REQ-037 SHALL cover reset mid-packet: rst_n low 1 cycle during a tx_valid=1 stall -> next cycle all outputs are at reset values and rr_ptr=0.
REQ-038 SHALL cover wrap-around: owner 3 releases with NUM_REQ=4 and reqs 0 and 3 valid -> req 0 is granted.
